// File: rtl/seg_scan_gen_if.sv
// seg_scan_gen_if: value/control bus between score logic and the scanned display driver
//   val_in, load, blink, dp_mask : driven by the score logic (master)
//   busy, SEG, SEG_switch        : driven by seg_scan_gen (slave)
interface seg_scan_gen_if #(
    parameter int DIGITS = 3,
    parameter int VAL_W  = 10
);
    logic [VAL_W-1:0]  val_in;
    logic              load;
    logic              blink;
    logic [DIGITS-1:0] dp_mask;
    logic              busy;
    logic [7:0]        SEG;
    logic [DIGITS-1:0] SEG_switch;
    modport master (output val_in, load, blink, dp_mask, input busy, SEG, SEG_switch);
    modport slave  (input val_in, load, blink, dp_mask, output busy, SEG, SEG_switch);
endinterface

// File: rtl/seg_scan_gen.sv
// seg_scan_gen: double-dabble binary-to-BCD converter feeding a multiplexed seven-segment scanner
//   clk, rst (async, active high)
//   bus.val_in/load : value latched on load while idle; bus.busy high during conversion
//   bus.blink/dp_mask : whole-display flash and per-digit decimal points
//   bus.SEG/SEG_switch : registered segment pattern {dp,g..a} and one-hot digit enable
module seg_scan_gen #(
    parameter int DIGITS    = 3,
    parameter int VAL_W     = 10,
    parameter int SCAN_DIV  = 50000,
    parameter int BLINK_DIV = 250,
    parameter int LZB       = 1
) (
    input logic          clk,
    input logic          rst,
    seg_scan_gen_if.slave bus
);
    localparam int IW    = DIGITS > 1 ? $clog2(DIGITS) : 1;
    localparam int SW    = $clog2(SCAN_DIV + 1);
    localparam int BW    = $clog2(BLINK_DIV + 1);
    localparam int CW    = $clog2(VAL_W + 1);
    localparam int BCD_W = 4 * DIGITS;
    localparam logic [VAL_W-1:0] MAXV = VAL_W'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;

    logic [SW-1:0]    scnt;
    logic [BW-1:0]    bcnt;
    logic             bph;
    logic [IW-1:0]    idx;
    logic [IW-1:0]    msd;
    logic [VAL_W-1:0] val_q;
    logic [VAL_W-1:0] bin;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] adj;
    logic [BCD_W-1:0] dbuf;
    logic [CW-1:0]    iter;
    logic             ovf;
    logic             tick;
    logic             lead;
    logic [3:0]       nib;
    logic [6:0]       glyph;
    logic [7:0]       seg_d;

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    assign tick = scnt == SW'(SCAN_DIV - 1);

    always_comb begin
        adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = bcd[4*i +: 4] >= 4'd5 ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    end

    always_comb begin
        state_n  = state;
        bus.busy = state != IDLE;
        case (state)
            IDLE:    state_n = bus.load ? SHIFT : IDLE;
            SHIFT:   state_n = iter == CW'(VAL_W - 1) ? DONE : SHIFT;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            val_q <= '0;
            bin   <= '0;
            bcd   <= '0;
            iter  <= '0;
            dbuf  <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (bus.load) begin
                    val_q <= bus.val_in;
                    bin   <= bus.val_in;
                    bcd   <= '0;
                    iter  <= '0;
                end
                SHIFT: begin
                    {bcd, bin} <= {adj[BCD_W-2:0], bin, 1'b0};
                    iter       <= iter + CW'(1);
                end
                default: begin
                    dbuf <= bcd;
                    ovf  <= val_q > MAXV;
                end
            endcase
        end
    end

    // msd marks the highest non-zero digit; digit 0 is never treated as leading
    always_comb begin
        msd = '0;
        for (int i = 1; i < DIGITS; i++)
            if (dbuf[4*i +: 4] != 4'd0) msd = IW'(i);
        nib   = dbuf[4*idx +: 4];
        lead  = LZB != 0 && idx > msd;
        glyph = ovf ? 7'h79 : lead ? 7'h00 : seg7(nib);
        seg_d = bus.blink && bph ? 8'h00 : {bus.dp_mask[idx], glyph};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scnt           <= '0;
            bcnt           <= '0;
            bph            <= 1'b0;
            idx            <= '0;
            bus.SEG        <= '0;
            bus.SEG_switch <= '0;
        end else begin
            scnt <= tick ? '0 : scnt + SW'(1);
            if (tick) begin
                idx            <= idx == IW'(DIGITS - 1) ? '0 : idx + IW'(1);
                bcnt           <= bcnt == BW'(BLINK_DIV - 1) ? '0 : bcnt + BW'(1);
                bph            <= bcnt == BW'(BLINK_DIV - 1) ? ~bph : bph;
                bus.SEG        <= seg_d;
                bus.SEG_switch <= DIGITS'(1) << idx;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_gen.sv
// tb_seg_scan_gen: table-driven check of conversion, scan rotation, blanking, overflow, blink and reset
module tb_seg_scan_gen;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   clk_n;
    int   n_vec = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    // clocks since reset release; scan tick k lands on clock 4k
    always @(posedge clk or posedge rst) begin
        if (rst) clk_n <= 0;
        else     clk_n <= clk_n + 1;
    end

    seg_scan_gen_if #(.DIGITS(4), .VAL_W(14)) b0 ();
    seg_scan_gen_if #(.DIGITS(4), .VAL_W(14)) b1 ();

    seg_scan_gen #(.DIGITS(4), .VAL_W(14), .SCAN_DIV(4), .BLINK_DIV(2), .LZB(0))
        d0 (.clk(clk), .rst(rst), .bus(b0.slave));
    seg_scan_gen #(.DIGITS(4), .VAL_W(14), .SCAN_DIV(4), .BLINK_DIV(2), .LZB(1))
        d1 (.clk(clk), .rst(rst), .bus(b1.slave));

    typedef struct {
        logic [13:0] val;
        bit          lzb;
        logic [3:0]  dp;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [11];

    function automatic logic [7:0] seg_of(input bit s);
        return s ? b1.SEG : b0.SEG;
    endfunction

    function automatic logic [3:0] sw_of(input bit s);
        return s ? b1.SEG_switch : b0.SEG_switch;
    endfunction

    function automatic logic busy_of(input bit s);
        return s ? b1.busy : b0.busy;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [13:0] v, input logic [3:0] dp, input logic bl);
        b0.val_in = v;  b1.val_in = v;
        b0.dp_mask = dp; b1.dp_mask = dp;
        b0.blink = bl;  b1.blink = bl;
    endtask

    task automatic pulse_load();
        b0.load = 1'b1; b1.load = 1'b1;
        @(negedge clk);
        b0.load = 1'b0; b1.load = 1'b0;
    endtask

    task automatic wait_tick();
        @(negedge clk);
        while (clk_n % 4 != 0) @(negedge clk);
    endtask

    task automatic busy_len(input bit s, input string name);
        int n = 0;
        while (busy_of(s) && n < 40) begin
            n++;
            @(negedge clk);
        end
        chk(name, n, 15);
    endtask

    // exp packs {slot3,slot2,slot1,slot0}; in blink mode off-phase slots must be dark
    task automatic check_round(input bit s, input logic [31:0] exp, input bit blinking, input int nt);
        logic [31:0] e;
        for (int t = 0; t < nt; t++) begin
            int k, slot;
            bit off;
            wait_tick();
            k    = clk_n / 4;
            slot = (k - 1) % 4;
            off  = blinking && (((k - 1) / 2) % 2 == 1);
            e    = off ? 32'h0 : {24'h0, exp[8*slot +: 8]};
            chk($sformatf("seg slot%0d k%0d", slot, k), {24'h0, seg_of(s)}, e);
            chk($sformatf("sw slot%0d k%0d", slot, k), {28'h0, sw_of(s)}, 32'h1 << slot);
            @(negedge clk);
            chk($sformatf("sw hold slot%0d", slot), {28'h0, sw_of(s)}, 32'h1 << slot);
        end
    endtask

    initial begin
        tbl[0]  = '{14'd1234,  1'b0, 4'b0000, 32'h065B4F66};
        tbl[1]  = '{14'd10000, 1'b0, 4'b0000, 32'h79797979};
        tbl[2]  = '{14'd7,     1'b1, 4'b0000, 32'h00000007};
        tbl[3]  = '{14'd0,     1'b1, 4'b0000, 32'h0000003F};
        tbl[4]  = '{14'd0,     1'b0, 4'b0000, 32'h3F3F3F3F};
        tbl[5]  = '{14'd9999,  1'b1, 4'b0000, 32'h6F6F6F6F};
        tbl[6]  = '{14'd305,   1'b1, 4'b0000, 32'h004F3F6D};
        tbl[7]  = '{14'd10000, 1'b1, 4'b0000, 32'h79797979};
        tbl[8]  = '{14'd8060,  1'b0, 4'b0101, 32'h7FBF7DBF};
        tbl[9]  = '{14'd16383, 1'b0, 4'b0000, 32'h79797979};
        tbl[10] = '{14'd40,    1'b1, 4'b1000, 32'h8000663F};

        b0.load = 1'b0; b1.load = 1'b0;
        drive(14'd0, 4'b0000, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst seg", {24'h0, b0.SEG}, 32'h0);
        chk("rst sw", {28'h0, b0.SEG_switch}, 32'h0);
        chk("rst busy", {31'h0, b0.busy}, 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        chk("sw before first tick", {28'h0, b0.SEG_switch}, 32'h0);

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].val, tbl[i].dp, 1'b0);
            pulse_load();
            busy_len(tbl[i].lzb, $sformatf("busy len v%0d", i));
            check_round(tbl[i].lzb, tbl[i].exp, 1'b0, 4);
        end

        // second load during busy is dropped
        drive(14'd1234, 4'b0000, 1'b0);
        pulse_load();
        begin
            int n = 0;
            while (b0.busy && n < 40) begin
                n++;
                b0.load = n == 3; b1.load = n == 3;
                if (n == 3) begin b0.val_in = 14'd5678; b1.val_in = 14'd5678; end
                @(negedge clk);
            end
            b0.load = 1'b0; b1.load = 1'b0;
            chk("busy len with ignored load", n, 15);
        end
        check_round(1'b0, 32'h065B4F66, 1'b0, 4);

        // reset in the middle of a conversion
        drive(14'd5678, 4'b0000, 1'b0);
        pulse_load();
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid rst busy", {31'h0, b0.busy}, 32'h0);
        chk("mid rst seg", {24'h0, b0.SEG}, 32'h0);
        chk("mid rst sw", {28'h0, b0.SEG_switch}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        wait_tick();
        chk("post rst seg0", {24'h0, b0.SEG}, 32'h3F);
        chk("post rst sw0", {28'h0, b0.SEG_switch}, 32'h1);
        chk("post rst seg0 lzb", {24'h0, b1.SEG}, 32'h3F);
        chk("post rst busy", {31'h0, b0.busy}, 32'h0);

        // blink with a decimal point on digit 1
        drive(14'd1234, 4'b0000, 1'b0);
        pulse_load();
        busy_len(1'b0, "busy len blink load");
        drive(14'd1234, 4'b0010, 1'b1);
        check_round(1'b0, 32'h065BCF66, 1'b1, 8);
        drive(14'd1234, 4'b0000, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/seg_scan_gen.md
Name: seg_scan_gen

Overview:
- Parametrised successor to the 3-digit reaction-timer display driver.
- Takes a binary value on a load strobe and converts it to BCD sequentially with a shift-add-3 (double-dabble) engine.
- Time-multiplexes DIGITS seven-segment digits and adds leading-zero blanking, overflow indication, blink mode and per-digit decimal points.
- Sits between the game/score logic and the board SEG/SEG_switch pins. Replaces the per-result divide/modulo chains with one shared converter.

Parameters:
- DIGITS, 3, number of multiplexed digits (1..6).
- VAL_W, 10, binary input width; must satisfy 2^VAL_W > 10^DIGITS-1.
- SCAN_DIV, 50000, clk cycles per digit slot (50 MHz -> 1 kHz scan).
- BLINK_DIV, 250, scan ticks per blink half-period.
- LZB, 1, 1 = blank leading zeros (digit 0 always lit).

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- val_in, input, VAL_W, binary value to display.
- load, input, 1, single-cycle strobe; sampled only when busy=0.
- blink, input, 1, 1 = flash the whole display.
- dp_mask, input, DIGITS, decimal-point enable per digit (bit0 = ones digit).
- busy, output, 1, conversion in progress.
- SEG, output, 8, segments active-high {dp,g,f,e,d,c,b,a}.
- SEG_switch, output, DIGITS, one-hot digit enable active-high (bit0 = ones digit).

Behaviour:
- Reset state (async): SEG=0, SEG_switch=0, busy=0, display buffer = all-zero BCD, overflow flag=0, scan and blink counters=0, digit index=0.
- Scan timing:
  - Prescaler counts 0..SCAN_DIV-1; a scan tick fires on terminal count.
  - Each tick advances the digit index, wrapping DIGITS-1 -> 0.
  - SEG_switch stays 0 until the first tick after reset; the first lit digit is index 0.
- Outputs: SEG and SEG_switch are registered and change only on a scan tick. They always reflect the digit selected and the buffer contents at that tick.
- Converter FSM states: IDLE, SHIFT, DONE.
  - IDLE: load=1 latches val_in, clears the BCD scratch register and goes to SHIFT. busy goes 1 the next cycle.
  - SHIFT: runs VAL_W iterations, one per clk. Each iteration first adds 3 to every BCD nibble >=5, then shifts the {BCD, binary} pair left by 1.
  - DONE: one cycle. Copies scratch to the display buffer atomically and sets overflow = (latched value > 10^DIGITS-1). Returns to IDLE.
  - busy is high for exactly VAL_W+1 cycles. The buffer never shows a partial result.
- load while busy=1 is ignored; no queueing.
- Digit decode, first match wins:
  - blink=1 and blink phase off: SEG=0 with SEG_switch still cycling. The blink phase toggles every BLINK_DIV scan ticks and the counter runs freely.
  - overflow=1: every digit shows 'E' = 0x79.
  - LZB=1 and the digit is above the most significant non-zero digit: SEG=0. A value of 0 shows a single '0' in digit 0.
  - Otherwise: standard 0-9 table (0x3F, 0x06, 0x5B, 0x4F, 0x66, 0x6D, 0x7D, 0x07, 0x7F, 0x6F).
  - dp_mask[i] ORs bit7 into digit i, except in the blink-off phase.
- Reset during SHIFT: aborts the conversion and returns to the reset state; the previous buffer is lost.
- Scanning is independent of conversion; the old value stays on display until DONE.

Test Plan:
- DIGITS=4, VAL_W=14, SCAN_DIV=4, LZB=0; load val_in=1234 -> busy high 15 cycles; afterwards the digit0..3 slots show SEG 0x66, 0x4F, 0x5B, 0x06 with SEG_switch 0001, 0010, 0100, 1000, each held 4 clks.
- Same config; load 10000 -> overflow; all four slots SEG=0x79.
- LZB=1; load 7 -> slot0 SEG=0x07, slots1-3 SEG=0x00 while SEG_switch keeps rotating. Load 0 -> slot0 0x3F, others 0x00.
- Load 1234, then pulse load with 5678 at cycle 3 of busy -> second load ignored; display ends at 1234 and busy drops after exactly 15 cycles.
- blink=1, BLINK_DIV=2, dp_mask=0010 -> SEG alternates all-zero for 2 ticks / digits for 2 ticks; slot1 shows 0x4F|0x80=0xCF in the on-phase.
- Assert rst at cycle 5 of a conversion -> busy=0, SEG=0, SEG_switch=0 immediately. After release, the first tick shows '0' in digit 0 (0x3F).
